// File: rtl/zstr_drn.sv
// Consumer side of a z stream: paces z_rdy from a queue of per-transfer delays
// and captures every transferred word into a data queue read back by the host.
module zstr_drn #(
  parameter int BW   = 1,
  parameter int QL   = 4,
  parameter int QW   = $clog2(QL),
  parameter int DFLT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                z_vld,
  input  logic [BW-1:0]       z_bus,
  output logic                z_rdy,
  input  logic                i_tmg_put,
  input  logic signed [31:0]  i_tmg,
  output logic [1:0]          o_tmg_sts,
  input  logic                i_bus_get,
  output logic [BW-1:0]       o_bus,
  output logic                o_bus_sts
);

  localparam int AW = (QW > 0) ? QW : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] QL_C = CW'(QL);
  localparam logic [AW-1:0] LAST = AW'(QL - 1);
  localparam logic signed [31:0] DFLT_S = DFLT;
  localparam logic signed [31:0] CNT_MAX = 32'sh7fff_ffff;

  // Monotonic counts give occupancy; separate pointers allow non-power-of-two QL.
  logic [CW-1:0] r_dwr, r_drd, r_twr, r_trd;
  logic [AW-1:0] r_dwp, r_drp, r_twp, r_trp;
  logic signed [31:0] r_cnt;
  logic [BW-1:0] r_dmem [QL];
  logic signed [31:0] r_tmem [QL];

  logic [CW-1:0] w_docc, w_tocc;
  logic w_dfull, w_dempty, w_tfull, w_tempty;
  logic signed [31:0] w_dly;
  logic w_rdy, w_trn, w_tput, w_get;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  assign w_docc   = r_dwr - r_drd;
  assign w_tocc   = r_twr - r_trd;
  assign w_dfull  = (w_docc >= QL_C);
  assign w_dempty = (w_docc == '0);
  assign w_tfull  = (w_tocc >= QL_C);
  assign w_tempty = (w_tocc == '0);

  assign w_dly = w_tempty ? DFLT_S : r_tmem[r_trp];
  assign w_rdy = (r_cnt >= w_dly) && !w_dfull;
  assign w_trn = z_vld && w_rdy;
  assign z_rdy = w_rdy;

  always_comb begin
    o_tmg_sts = 2'd0;
    if (w_tfull)
      o_tmg_sts = 2'd1;
    else if (i_tmg < 0)
      o_tmg_sts = 2'd2;
  end
  assign w_tput = i_tmg_put && (o_tmg_sts == 2'd0);

  assign o_bus     = r_dmem[r_drp];
  assign o_bus_sts = w_dempty;
  assign w_get     = i_bus_get && !w_dempty;

  // Stream side: owns data write, timing read and the valid-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwr <= '0;
      r_dwp <= '0;
      r_trd <= '0;
      r_trp <= '0;
      r_cnt <= '0;
    end else if (w_trn) begin
      r_dwr <= r_dwr + CW'(1);
      r_dwp <= nxt(r_dwp);
      r_cnt <= '0;
      if (!w_tempty) begin
        r_trd <= r_trd + CW'(1);
        r_trp <= nxt(r_trp);
      end
    end else if (z_vld && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 32'sd1;
    end
  end

  // Host side: owns timing write and data read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_twr <= '0;
      r_twp <= '0;
      r_drd <= '0;
      r_drp <= '0;
    end else begin
      if (w_tput) begin
        r_twr <= r_twr + CW'(1);
        r_twp <= nxt(r_twp);
      end
      if (w_get) begin
        r_drd <= r_drd + CW'(1);
        r_drp <= nxt(r_drp);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_trn)
      r_dmem[r_dwp] <= z_bus;
    if (w_tput)
      r_tmem[r_twp] <= i_tmg;
  end

endmodule

// File: tb/tb_zstr_drn.sv
// Bench for zstr_drn: directed scenarios plus random traffic checked against
// a queue-based model of the drain.
module tb_zstr_drn;
  localparam int BW = 4;
  localparam int QL = 4;
  localparam int DFLT = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic z_vld = 1'b0;
  logic [BW-1:0] z_bus = '0;
  logic z_rdy;
  logic i_tmg_put = 1'b0;
  logic signed [31:0] i_tmg = '0;
  logic [1:0] o_tmg_sts;
  logic i_bus_get = 1'b0;
  logic [BW-1:0] o_bus;
  logic o_bus_sts;

  zstr_drn #(.BW(BW), .QL(QL), .DFLT(DFLT)) dut (
    .clk(clk), .rst(rst), .z_vld(z_vld), .z_bus(z_bus), .z_rdy(z_rdy),
    .i_tmg_put(i_tmg_put), .i_tmg(i_tmg), .o_tmg_sts(o_tmg_sts),
    .i_bus_get(i_bus_get), .o_bus(o_bus), .o_bus_sts(o_bus_sts)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;
  int tq[$];
  logic [BW-1:0] dq[$];
  int mcnt = 0;
  int obs_rdy, obs_tsts, obs_gsts;
  logic [BW-1:0] obs_bus;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    tq.delete();
    dq.delete();
    mcnt = 0;
  endtask

  // One clock cycle: called at negedge with inputs driven; checks, updates model.
  task automatic tick();
    int dly, erdy, ets, egs;
    bit tnon, dnon;
    #1;
    dly  = (tq.size() > 0) ? tq[0] : DFLT;
    erdy = (mcnt >= dly && dq.size() < QL) ? 1 : 0;
    obs_rdy = int'(z_rdy);
    chk("rdy", 32'(z_rdy), 32'(erdy));
    if (i_tmg_put) begin
      ets = (tq.size() >= QL) ? 1 : ((i_tmg < 0) ? 2 : 0);
      obs_tsts = int'(o_tmg_sts);
      chk("tmg_sts", 32'(o_tmg_sts), 32'(ets));
    end
    if (i_bus_get) begin
      egs = (dq.size() == 0) ? 1 : 0;
      obs_gsts = int'(o_bus_sts);
      obs_bus = o_bus;
      chk("get_sts", 32'(o_bus_sts), 32'(egs));
      if (egs == 0) chk("get_bus", 32'(o_bus), 32'(dq[0]));
    end
    tnon = tq.size() > 0;
    dnon = dq.size() > 0;
    if (i_bus_get && dnon) void'(dq.pop_front());
    if (z_vld && erdy == 1) begin
      if (tnon) void'(tq.pop_front());
      dq.push_back(z_bus);
      mcnt = 0;
    end else if (z_vld) begin
      mcnt++;
    end
    if (i_tmg_put && tq.size() < QL + (tnon && z_vld && erdy == 1 ? 1 : 0) && i_tmg >= 0
        && !(tnon == 1'b0 && 0 > 1))
      ;
    if (i_tmg_put && ets == 0) tq.push_back(i_tmg);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put_tmg(output int sts, input int tmg);
    i_tmg_put = 1'b1;
    i_tmg = tmg;
    tick();
    sts = obs_tsts;
    i_tmg_put = 1'b0;
    $display("put_tmg tmg=%0d sts=%0d", tmg, sts);
  endtask

  task automatic get_bus(output int sts, inout logic [BW-1:0] bus);
    i_bus_get = 1'b1;
    tick();
    sts = obs_gsts;
    if (sts == 0) bus = obs_bus;
    i_bus_get = 1'b0;
    $display("get_bus sts=%0d bus=0x%0h", sts, bus);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rdy", 32'(z_rdy), 32'(DFLT <= 0));
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int s, t;
    logic [BW-1:0] b;
    b = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rdy", 32'(z_rdy), 32'(1));
    @(negedge clk);
    rst = 1'b0;
    model_clear();

    // 1: back-to-back words with default delay
    tick();
    chk("t1_rdy", 32'(obs_rdy), 32'(1));
    z_vld = 1'b1;
    z_bus = 4'hA; tick();
    z_bus = 4'hB; tick();
    z_bus = 4'hC; tick();
    z_vld = 1'b0;
    get_bus(s, b); chk("t1_sts0", 32'(s), 0); chk("t1_a", 32'(b), 32'hA);
    get_bus(s, b); chk("t1_sts1", 32'(s), 0); chk("t1_b", 32'(b), 32'hB);
    get_bus(s, b); chk("t1_sts2", 32'(s), 0); chk("t1_c", 32'(b), 32'hC);
    get_bus(s, b); chk("t1_empty", 32'(s), 1);

    // 2: delay of 3 with valid held
    put_tmg(s, 3); chk("t2_put", 32'(s), 0);
    z_vld = 1'b1; z_bus = 4'h2;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_rdy", 32'(obs_rdy), 32'(i == 3));
    end
    z_vld = 1'b0;
    get_bus(s, b); chk("t2_bus", 32'(b), 32'h2);

    // 3: counter holds while valid is low
    put_tmg(s, 3);
    z_vld = 1'b1; z_bus = 4'h3; tick(); chk("t3_rdy0", 32'(obs_rdy), 0);
    z_vld = 1'b0; tick(); tick();
    z_vld = 1'b1;
    tick(); chk("t3_rdy1", 32'(obs_rdy), 0);
    tick(); chk("t3_rdy2", 32'(obs_rdy), 0);
    tick(); chk("t3_rdy3", 32'(obs_rdy), 1);
    z_vld = 1'b0;
    get_bus(s, b); chk("t3_bus", 32'(b), 32'h3);

    // 4: data queue full backpressure
    z_vld = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      z_bus = BW'(i);
      tick();
    end
    z_bus = 4'h5;
    tick(); chk("t4_full", 32'(obs_rdy), 0);
    get_bus(s, b); chk("t4_get_rdy", 32'(obs_rdy), 0); chk("t4_first", 32'(b), 32'h1);
    tick(); chk("t4_resume", 32'(obs_rdy), 1);
    z_vld = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      get_bus(s, b);
      chk("t4_word", 32'(b), 32'(i));
    end

    // 5: timing queue status codes
    put_tmg(s, -1); chk("t5_neg", 32'(s), 2);
    for (int i = 0; i < 5; i++) begin
      put_tmg(s, 0);
      chk("t5_sts", 32'(s), (i < 4) ? 0 : 1);
    end
    do_reset();

    // 6: reset mid-wait discards pending delay and data
    put_tmg(s, 5);
    z_vld = 1'b1; z_bus = 4'h7;
    tick(); chk("t6_w0", 32'(obs_rdy), 0);
    tick(); chk("t6_w1", 32'(obs_rdy), 0);
    z_vld = 1'b0;
    do_reset();
    tick(); chk("t6_rdy", 32'(obs_rdy), 1);
    b = 4'h9;
    get_bus(s, b); chk("t6_empty", 32'(s), 1); chk("t6_keep", 32'(b), 32'h9);
    z_vld = 1'b1; z_bus = 4'h6;
    tick(); chk("t6_dflt", 32'(obs_rdy), 1);
    z_vld = 1'b0;
    get_bus(s, b); chk("t6_bus", 32'(b), 32'h6);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      z_vld = ($urandom_range(0, 3) != 0);
      z_bus = BW'($urandom);
      i_tmg_put = ($urandom_range(0, 3) == 0);
      t = int'($urandom_range(0, 6)) - 1;
      i_tmg = t;
      i_bus_get = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 96) == 0) begin
        i_tmg_put = 1'b0;
        i_bus_get = 1'b0;
        do_reset();
      end else begin
        tick();
      end
      i_tmg_put = 1'b0;
      i_bus_get = 1'b0;
    end
    z_vld = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
